scanline_span_gen: RTL
======================

SCANLINE_SPAN_GEN -- requirements
Module: scanline_span_gen

Interface
REQ-001 SHALL have parameter COORD_W, default 16, the unsigned coordinate width.
REQ-002 SHALL have parameter FRAC_W, default 8, the number of fractional bits in the slope and edge accumulators.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit, request to rasterize one flat-edge triangle.
REQ-006 SHALL have ports v1_x, v1_y, v2_x, v2_y, v3_x, input, COORD_W bits each: apex vertex, then the flat-edge endpoints; v3_y is implied equal to v2_y.
REQ-007 SHALL have port busy, output, 1 bit, high from start acceptance until return to IDLE.
REQ-008 SHALL have ports span_valid (output, 1), span_ready (input, 1), span_y, span_x0, span_x1 (output, COORD_W each), span_last (output, 1): the span stream.
REQ-009 SHALL have ports done and err_degenerate, output, 1 bit each, single-cycle completion and fault pulses.

Function
REQ-010 SHALL implement FSM states IDLE, DIV1, DIV2, STEP, EMIT, FIN.
REQ-011 In IDLE with start=1, SHALL capture all vertex inputs, assert busy on the next cycle, and go to DIV1; start SHALL be ignored whenever busy=1.
REQ-012 On capture, if v2_x > v3_x, SHALL swap the two x values so that x0 <= x1 on the flat edge.
REQ-013 SHALL set ydir=+1 if v2_y >= v1_y, else -1, and dy=|v2_y - v1_y| as unsigned.
REQ-014 If dy=0, SHALL pulse err_degenerate for one cycle, emit no spans, skip done, and return to IDLE.
REQ-015 SHALL compute slope_k=((vk_x - v1_x) << FRAC_W)/dy as signed, truncated toward zero, using one shared sequential restoring divider.
REQ-016 The divider SHALL take exactly COORD_W+FRAC_W cycles per quotient; DIV1 computes the left slope and DIV2 the right slope.
REQ-017 SHALL initialise accumulators acc0=acc1=v1_x << FRAC_W, signed, width COORD_W+FRAC_W+2.
REQ-018 SHALL produce row k=1..dy at span_y = v1_y + ydir*k; the apex row is never emitted.
REQ-019 For each row, STEP SHALL add the slopes to the accumulators (1 cycle); EMIT SHALL present span_x0=acc0>>>FRAC_W and span_x1=acc1>>>FRAC_W, each clamped to [0, 2^COORD_W-1].
REQ-020 On row k=dy, SHALL drive span_x0=v2_x and span_x1=v3_x (post-swap) exactly, and assert span_last=1.
REQ-021 The first span_valid SHALL rise exactly 2*(COORD_W+FRAC_W)+2 cycles after the start-accept edge.
REQ-022 Handshake: a transfer occurs when span_valid and span_ready are both 1; while span_valid=1 and span_ready=0, all span_* outputs SHALL hold stable.
REQ-023 After a transfer, span_valid SHALL deassert for the STEP cycle, giving a throughput of 1 span per 2 cycles with span_ready held high.
REQ-024 After the span_last transfer, SHALL enter FIN, pulse done for one cycle, clear busy, and return to IDLE.
REQ-025 A start asserted in the same cycle as the done pulse SHALL be ignored.

Reset
REQ-026 While rst_n=0, SHALL force state=IDLE and busy, span_valid, span_last, done, err_degenerate=0; span_y, span_x0, span_x1, the accumulators and the divider SHALL be 0.
REQ-027 Deassertion of rst_n mid-operation SHALL leave the block in IDLE with no residual span emitted.

Verification
REQ-028 Flat-bottom: v1=(10,0), v2=(6,4), v3=(14,4), span_ready=1 -> spans (y,x0,x1) = (1,9,11), (2,8,12), (3,7,13), (4,6,14) with last set, then one done pulse.
REQ-029 Flat-top with swap: v1=(10,8), v2=(14,4), v3=(6,4) -> spans (7,9,11), (6,8,12), (5,7,13), (4,6,14).
REQ-030 Fractional slope: v1=(0,0), v2=(0,3), v3=(1,3) -> spans (1,0,0), (2,0,0), (3,0,1); slope_right=85.
REQ-031 Degenerate: v1_y=v2_y=5 -> err_degenerate pulses once, no span_valid, no done, busy drops after 2 cycles.
REQ-032 Backpressure: run REQ-028 with span_ready=0 for 3 cycles at row 2 -> (2,8,12) held unchanged, no rows skipped or repeated.
REQ-033 Reset mid-EMIT: assert rst_n=0 at row 2 of REQ-028 -> all outputs 0 asynchronously; after release, a new start reproduces the full REQ-028 sequence.

Source files
------------

// File: rtl/scanline_span_gen_if.sv
// Span output stream: one horizontal span per beat, valid/ready handshake.
interface scanline_span_gen_if #(
   parameter int COORD_W = 16
);
   logic               span_valid;
   logic               span_ready;
   logic [COORD_W-1:0] span_y;
   logic [COORD_W-1:0] span_x0;
   logic [COORD_W-1:0] span_x1;
   logic               span_last;

   modport master (output span_valid, span_y, span_x0, span_x1, span_last, input span_ready);
   modport slave  (input span_valid, span_y, span_x0, span_x1, span_last, output span_ready);
endinterface

// File: rtl/scanline_span_gen.sv
// Flat-edge triangle rasterizer: two divider passes for edge slopes, then one span per row.
//   state | meaning
//   IDLE  | waiting for start, vertices captured on accept
//   DIV1  | degenerate check, then left-edge slope division
//   DIV2  | right-edge slope division, accumulators seeded from apex
//   STEP  | advance accumulators one row, load span outputs
//   EMIT  | span presented, held until span_ready
//   FIN   | pulse done, drop busy
module scanline_span_gen #(
   parameter int COORD_W = 16,
   parameter int FRAC_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [COORD_W-1:0] v1_x,
   input  logic [COORD_W-1:0] v1_y,
   input  logic [COORD_W-1:0] v2_x,
   input  logic [COORD_W-1:0] v2_y,
   input  logic [COORD_W-1:0] v3_x,
   output logic               busy,
   output logic               done,
   output logic               err_degenerate,
   scanline_span_gen_if.master span
);
   localparam int DIV_N = COORD_W + FRAC_W;
   localparam int ACC_W = DIV_N + 2;
   localparam int CNT_W = $clog2(DIV_N);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_N - 1);

   typedef enum logic [2:0] {IDLE, DIV1, DIV2, STEP, EMIT, FIN} state_t;
   state_t state;

   logic [COORD_W-1:0]      v1x, x0, x1, dy, ycur, row;
   logic                    ydir_neg, div_load, quo_neg;
   logic signed [ACC_W-1:0] acc0, acc1, slope0, slope1;
   logic [COORD_W-1:0]      rem;
   logic [DIV_N-1:0]        quo;
   logic [CNT_W-1:0]        cnt;

   logic [COORD_W:0]        rem_sh, trial;
   logic [COORD_W-1:0]      rem_nx, mag0, mag1, row_nx, y_nx;
   logic [DIV_N-1:0]        quo_nx;
   logic signed [ACC_W-1:0] quo_ext, div_res, acc0_nx, acc1_nx;
   logic                    neg0, neg1, last_row;

   // Clamp the integer part of an accumulator into the coordinate range.
   function automatic logic [COORD_W-1:0] clamp(input logic signed [ACC_W-1:0] a);
      if (a[ACC_W-1])      return '0;
      else if (a[ACC_W-2]) return '1;
      else                 return a[ACC_W-3:FRAC_W];
   endfunction

   always_comb begin
      rem_sh   = {rem, quo[DIV_N-1]};
      // rem_sh < 2*dy, so a W+1 bit difference is enough to read the sign
      trial    = rem_sh - {1'b0, dy};
      rem_nx   = trial[COORD_W] ? rem_sh[COORD_W-1:0] : trial[COORD_W-1:0];
      quo_nx   = {quo[DIV_N-2:0], ~trial[COORD_W]};
      quo_ext  = {2'b00, quo_nx};
      div_res  = quo_neg ? -quo_ext : quo_ext;
      neg0     = x0 < v1x;
      neg1     = x1 < v1x;
      mag0     = neg0 ? (v1x - x0) : (x0 - v1x);
      mag1     = neg1 ? (v1x - x1) : (x1 - v1x);
      acc0_nx  = acc0 + slope0;
      acc1_nx  = acc1 + slope1;
      row_nx   = row + 1'b1;
      last_row = (row_nx == dy);
      y_nx     = ydir_neg ? (ycur - 1'b1) : (ycur + 1'b1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         busy            <= 1'b0;
         done            <= 1'b0;
         err_degenerate  <= 1'b0;
         span.span_valid <= 1'b0;
         span.span_last  <= 1'b0;
         span.span_y     <= '0;
         span.span_x0    <= '0;
         span.span_x1    <= '0;
         v1x <= '0; x0 <= '0; x1 <= '0; dy <= '0; ycur <= '0; row <= '0;
         ydir_neg <= 1'b0; div_load <= 1'b0; quo_neg <= 1'b0;
         acc0 <= '0; acc1 <= '0; slope0 <= '0; slope1 <= '0;
         rem <= '0; quo <= '0; cnt <= '0;
      end else begin
         done           <= 1'b0;
         err_degenerate <= 1'b0;
         case (state)
            IDLE: begin
               // done/err are high only in the cycle after completion; a start there is dropped
               if (start && !done && !err_degenerate) begin
                  v1x      <= v1_x;
                  x0       <= (v2_x > v3_x) ? v3_x : v2_x;
                  x1       <= (v2_x > v3_x) ? v2_x : v3_x;
                  ydir_neg <= v2_y < v1_y;
                  dy       <= (v2_y >= v1_y) ? (v2_y - v1_y) : (v1_y - v2_y);
                  ycur     <= v1_y;
                  busy     <= 1'b1;
                  div_load <= 1'b1;
                  state    <= DIV1;
               end
            end
            DIV1: begin
               if (div_load) begin
                  div_load <= 1'b0;
                  if (dy == '0) begin
                     err_degenerate <= 1'b1;
                     busy           <= 1'b0;
                     state          <= IDLE;
                  end else begin
                     quo     <= {mag0, {FRAC_W{1'b0}}};
                     rem     <= '0;
                     quo_neg <= neg0;
                     cnt     <= '0;
                  end
               end else if (cnt == CNT_LAST) begin
                  slope0  <= div_res;
                  quo     <= {mag1, {FRAC_W{1'b0}}};
                  rem     <= '0;
                  quo_neg <= neg1;
                  cnt     <= '0;
                  state   <= DIV2;
               end else begin
                  quo <= quo_nx;
                  rem <= rem_nx;
                  cnt <= cnt + 1'b1;
               end
            end
            DIV2: begin
               quo <= quo_nx;
               rem <= rem_nx;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  slope1 <= div_res;
                  acc0   <= {2'b00, v1x, {FRAC_W{1'b0}}};
                  acc1   <= {2'b00, v1x, {FRAC_W{1'b0}}};
                  row    <= '0;
                  state  <= STEP;
               end
            end
            STEP: begin
               acc0            <= acc0_nx;
               acc1            <= acc1_nx;
               row             <= row_nx;
               ycur            <= y_nx;
               span.span_y     <= y_nx;
               span.span_x0    <= last_row ? x0 : clamp(acc0_nx);
               span.span_x1    <= last_row ? x1 : clamp(acc1_nx);
               span.span_last  <= last_row;
               span.span_valid <= 1'b1;
               state           <= EMIT;
            end
            EMIT: begin
               if (span.span_ready) begin
                  span.span_valid <= 1'b0;
                  state           <= span.span_last ? FIN : STEP;
               end
            end
            FIN: begin
               done           <= 1'b1;
               busy           <= 1'b0;
               span.span_last <= 1'b0;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
